// File: rtl/idct_frame_ctrl.sv
// Frame issue controller for the IDCT path: accepts frame requests, streams beat
// addresses toward the IFFT sink, and tracks frames still inside the IFFT/scaling pipe.
module idct_frame_ctrl #(
  parameter int MAX_INFLIGHT = 2,
  parameter int wAddr        = 11
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [11:0]      req_fftpts,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic [11:0]      out_fftpts,
  output logic [wAddr-1:0] rd_addr,
  input  logic             ret_valid,
  input  logic             ret_eop,
  output logic [1:0]       inflight,
  output logic             busy,
  output logic             err_len
);

  typedef enum logic [1:0] {IDLE, STREAM, HOLD} state_t;

  localparam logic [1:0]  MaxInfl = 2'(MAX_INFLIGHT);
  localparam logic [11:0] LenDef  = 12'd2048;

  state_t             state_q, state_d;
  logic [11:0]        cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic               ready_q, ready_d;
  logic [wAddr-1:0]   addr_q, addr_d;
  logic [11:0]        fpts_q, fpts_d;
  logic [1:0]         infl_q, infl_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               armed_q, armed_d;
  logic               accept, xfer, inc, dec, room, legal;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      fpts_q  <= LenDef;
      infl_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      fpts_q  <= fpts_d;
      infl_q  <= infl_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    accept  = (state_q == IDLE) && ready_q && req_valid;
    xfer    = (state_q == STREAM) && valid_q && out_ready;
    inc     = xfer && eop_q;
    dec     = ret_valid && ret_eop && (infl_q != 2'd0);
    legal   = (req_fftpts == 12'd512) || (req_fftpts == 12'd2048);

    infl_d = infl_q;
    if (inc && !dec)      infl_d = infl_q + 2'd1;
    else if (dec && !inc) infl_d = infl_q - 2'd1;
    room = (infl_d < MaxInfl);

    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    ready_d = 1'b0;
    addr_d  = addr_q;
    fpts_d  = fpts_q;
    err_d   = 1'b0;
    // armed_q keeps req_ready low for the first cycle out of reset
    armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          fpts_d  = legal ? req_fftpts : LenDef;
          err_d   = !legal;
          state_d = STREAM;
          cnt_d   = '0;
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = 1'b0;
          addr_d  = '0;
        end else if (req_valid && (infl_q == MaxInfl)) begin
          state_d = HOLD;
        end else begin
          ready_d = room && armed_q;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (eop_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            // pre-arm req_ready so a waiting request costs only one idle beat
            ready_d = room;
          end else begin
            cnt_d  = cnt_q + 12'd1;
            addr_d = wAddr'(cnt_d);
            sop_d  = 1'b0;
            eop_d  = (cnt_d == fpts_q - 12'd1);
          end
        end
      end
      HOLD: begin
        if (infl_q < MaxInfl) begin
          state_d = IDLE;
          ready_d = room;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (infl_d != 2'd0);
  end

  assign req_ready  = ready_q;
  assign out_valid  = valid_q;
  assign out_sop    = sop_q;
  assign out_eop    = eop_q;
  assign out_fftpts = fpts_q;
  assign rd_addr    = addr_q;
  assign inflight   = infl_q;
  assign busy       = busy_q;
  assign err_len    = err_q;

endmodule

// File: tb/tb_idct_frame_ctrl.sv
// Directed bench for idct_frame_ctrl: table of frame requests plus hand-written
// sequences for back-pressure on inflight, coincident returns and mid-frame reset.
module tb_idct_frame_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_sync, req_valid, req_ready, out_valid, out_ready, out_sop, out_eop;
  logic        ret_valid, ret_eop, busy, err_len;
  logic [11:0] req_fftpts, out_fftpts;
  logic [10:0] rd_addr;
  logic [1:0]  inflight;

  int n_tests = 0;
  int n_fail  = 0;
  int last_wait;
  bit ret_at_eop = 1'b0;

  typedef struct {
    logic [11:0] fp;
    bit          tog;
    int          len;
    bit          err;
    int          exp_fp;
  } vec_t;

  vec_t tbl [5];

  idct_frame_ctrl #(.MAX_INFLIGHT(2), .wAddr(11)) dut (
    .clk(clk), .rst_sync(rst_sync),
    .req_valid(req_valid), .req_ready(req_ready), .req_fftpts(req_fftpts),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_fftpts(out_fftpts), .rd_addr(rd_addr),
    .ret_valid(ret_valid), .ret_eop(ret_eop),
    .inflight(inflight), .busy(busy), .err_len(err_len)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ret_pulse;
    ret_valid = 1'b1;
    ret_eop   = 1'b1;
    tick;
    ret_valid = 1'b0;
    ret_eop   = 1'b0;
  endtask

  task automatic run_frame(input logic [11:0] fp, input bit tog, input int len,
                           input bit err, input int exp_fp, input int exp_infl);
    int waited, n, errc, sopc, addr_bad, stall_bad, fp_bad, eop_addr, cyc;
    bit ph, stalled, done;
    logic [25:0] snap;
    req_fftpts = fp;
    req_valid  = 1'b1;
    waited     = 0;
    while (!req_ready && waited < 20) begin
      tick;
      waited++;
    end
    last_wait = waited;
    check("req_ready_seen", req_ready, 1);
    tick;
    req_valid = 1'b0;
    check("err_len_first", err_len, err);
    check("out_fftpts", out_fftpts, exp_fp);
    check("first_beat_sop_addr0", out_valid && out_sop && (rd_addr == 11'd0), 1);
    check("busy_streaming", busy, 1);
    n = 0; errc = 0; sopc = 0; addr_bad = 0; stall_bad = 0; fp_bad = 0;
    eop_addr = -1; ph = 1'b0; stalled = 1'b0; done = 1'b0; cyc = 0; snap = '0;
    while (!done && cyc < 6000) begin
      if (err_len) errc++;
      if (out_fftpts != 12'(exp_fp)) fp_bad++;
      if (stalled && ({out_valid, out_sop, out_eop, rd_addr, out_fftpts} !== snap)) stall_bad++;
      out_ready = tog ? ph : 1'b1;
      ph = !ph;
      if (out_valid && out_ready) begin
        n++;
        if (out_sop) sopc++;
        if (int'(rd_addr) != n - 1) addr_bad++;
        if (out_eop) begin
          done     = 1'b1;
          eop_addr = int'(rd_addr);
          if (ret_at_eop) begin
            ret_valid = 1'b1;
            ret_eop   = 1'b1;
          end
        end
      end
      stalled = out_valid && !out_ready;
      snap    = {out_valid, out_sop, out_eop, rd_addr, out_fftpts};
      tick;
      cyc++;
    end
    ret_valid = 1'b0;
    ret_eop   = 1'b0;
    out_ready = 1'b1;
    check("beat_count", n, len);
    check("sop_count", sopc, 1);
    check("addr_sequence_errors", addr_bad, 0);
    check("stall_instability", stall_bad, 0);
    check("fftpts_changes", fp_bad, 0);
    check("eop_addr", eop_addr, len - 1);
    check("err_len_cycles", errc, err);
    check("valid_low_after_eop", out_valid, 0);
    check("inflight_after_frame", inflight, exp_infl);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    tbl[0] = '{12'd512,  1'b0, 512,  1'b0, 512};
    tbl[1] = '{12'd2048, 1'b1, 2048, 1'b0, 2048};
    tbl[2] = '{12'd1024, 1'b0, 2048, 1'b1, 2048};
    tbl[3] = '{12'd512,  1'b1, 512,  1'b0, 512};
    tbl[4] = '{12'd0,    1'b0, 2048, 1'b1, 2048};

    rst_sync = 1'b1; req_valid = 1'b0; req_fftpts = '0;
    out_ready = 1'b1; ret_valid = 1'b0; ret_eop = 1'b0;
    repeat (3) tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_out_sop_eop", {out_sop, out_eop}, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_fftpts", out_fftpts, 2048);
    check("rst_inflight", inflight, 0);
    check("rst_busy", busy, 0);
    check("rst_err_len", err_len, 0);

    rst_sync = 1'b0;
    tick;
    check("ready_1st_cycle_after_rst", req_ready, 0);
    tick;
    check("ready_2nd_cycle_after_rst", req_ready, 1);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].fp, tbl[i].tog, tbl[i].len, tbl[i].err, tbl[i].exp_fp, 1);
      ret_pulse;
      check("inflight_drained", inflight, 0);
    end

    // back-to-back frames, then a third request blocked by inflight limit
    run_frame(12'd512, 1'b0, 512, 1'b0, 512, 1);
    run_frame(12'd512, 1'b0, 512, 1'b0, 512, 2);
    check("b2b_wait_cycles", last_wait, 0);
    req_fftpts = 12'd512;
    req_valid  = 1'b1;
    repeat (3) begin
      tick;
      check("hold_ready_low", req_ready, 0);
    end
    check("hold_busy", busy, 1);
    ret_pulse;
    check("inflight_after_ret", inflight, 1);
    w = 0;
    while (!req_ready && w < 3) begin
      tick;
      w++;
    end
    check("hold_release_ready", req_ready, 1);
    check("hold_release_fast", w <= 1, 1);
    run_frame(12'd512, 1'b0, 512, 1'b0, 512, 2);
    ret_pulse;
    ret_pulse;
    check("inflight_drained_2", inflight, 0);

    // return coincident with eop transfer, then return at zero
    run_frame(12'd512, 1'b0, 512, 1'b0, 512, 1);
    ret_at_eop = 1'b1;
    run_frame(12'd512, 1'b0, 512, 1'b0, 512, 1);
    ret_at_eop = 1'b0;
    ret_pulse;
    check("inflight_to_zero", inflight, 0);
    ret_pulse;
    check("ret_at_zero_no_wrap", inflight, 0);

    // reset in the middle of a frame
    run_frame(12'd512, 1'b0, 512, 1'b0, 512, 1);
    req_fftpts = 12'd512;
    req_valid  = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      tick;
      w++;
    end
    tick;
    req_valid = 1'b0;
    w = 0;
    while (rd_addr != 11'd300 && w < 600) begin
      tick;
      w++;
    end
    check("reached_beat_300", rd_addr, 300);
    rst_sync = 1'b1;
    tick;
    rst_sync = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_eop", out_eop, 0);
    check("midrst_inflight", inflight, 0);
    check("midrst_busy", busy, 0);
    run_frame(12'd512, 1'b0, 512, 1'b0, 512, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
